led_scan_driver: RTL and testbench
==================================

Name: led_scan_driver

Overview:
- Drives a multiplexed 12-digit seven-segment display from the clock's six 14-bit LED buses (sec, min, hour, day, month, year).
- Sits directly downstream of the clock/calendar core and consumes its led_* outputs.
- Time-multiplexes one digit at a time and blanks briefly between digits to prevent ghosting.
- Freezes a full-frame snapshot so a frame never mixes old and new values, and optionally blinks the field currently being edited.

Parameters:
- SCAN_DIV, 1000, clock cycles per digit slot; must be at least 2 and greater than BLANK_CYC.
- BLANK_CYC, 8, cycles at the start of each slot with all digit enables off; 0 or more.
- BLINK_FRAMES, 64, number of full 12-digit frames per blink half-period; at least 1.
- SEG_ACTIVE_LOW, 0, if 1 then seg_o and dig_o are inverted at the output register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- led_sec  in  14  [6:0] drives digit 0, [13:7] drives digit 1
- led_min  in  14  digits 2 and 3
- led_hour  in  14  digits 4 and 5
- led_day  in  14  digits 6 and 7
- led_month  in  14  digits 8 and 9
- led_year  in  14  digits 10 and 11
- blink_en  in  1  global blink enable (edit mode active)
- blink_sel  in  6  field blink mask: bit0 sec, bit1 min, bit2 hour, bit3 day, bit4 month, bit5 year
- seg_o  out  7  segment pattern of the active digit
- dig_o  out  12  one-hot digit enable; bit n selects digit n
- frame_start  out  1  one-cycle pulse when digit 0's slot begins at the outputs

Behaviour:
- State:
  - Prescaler p counts 0..SCAN_DIV-1.
  - Digit index idx counts 0..11. It advances when p==SCAN_DIV-1 and wraps from 11 to 0.
  - A blink frame counter and a blink_phase bit.
  - An 84-bit snapshot register.
- Snapshot: all six led_* buses are captured in any cycle where idx==0 and p==0, including the first cycle after reset is released. Input changes take effect only at the next frame boundary.
- Blink:
  - The frame counter increments on every idx 11->0 wrap.
  - When the counter reaches BLINK_FRAMES-1 and wraps, it returns to 0 and blink_phase toggles.
- Output registers (one cycle of latency from the (idx, p) state):
  - dig_o = onehot(idx) when p >= BLANK_CYC and the digit is not blinked; otherwise dig_o = 0.
  - A digit is blinked when blink_en=1, blink_sel[idx/2]=1 and blink_phase=1.
  - seg_o = snapshot bits for idx, i.e. bits [6:0] or [13:7] of the matching field. seg_o is driven even during blanking and blinking.
  - frame_start = 1 for exactly one cycle: the cycle after the state idx==0, p==0.
  - SEG_ACTIVE_LOW inverts seg_o and dig_o after this logic. The reset values below are logical, before inversion.
- Reset (synchronous, active-high):
  - p, idx, frame counter, blink_phase and snapshot go to 0.
  - seg_o = 0, dig_o = 0, frame_start = 0.
  - Reset asserted mid-slot or mid-frame aborts immediately; the next clock edge yields the reset outputs.
- Timing from reset release (R = first cycle with reset low):
  - frame_start is high at R+1.
  - Slot k is visible on the outputs during cycles R+1+k*SCAN_DIV .. R+(k+1)*SCAN_DIV.
  - The digit enable rises BLANK_CYC cycles into each slot.
  - Full frame period = 12*SCAN_DIV cycles.
- Boundary conditions:
  - blink_sel or blink_en changes take effect on the next cycle; they are not snapshotted.
  - BLANK_CYC=0: no blanking, and dig_o is never all-zero except in blink or reset.
  - At most one dig_o bit is high in any cycle.

Test Plan:
- Use SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2, SEG_ACTIVE_LOW=0 unless stated.
- Reset check: hold reset 3 cycles, release at R. Expect:
  - dig_o=0 and seg_o=0 during reset.
  - frame_start=1 at R+1 only.
  - dig_o=12'h001 at R+2..R+4.
  - dig_o=12'h002 at R+6..R+8.
  - dig_o=0 at R+5.
- Mapping: set led_sec=14'h1FFF? no, set led_sec={7'h06,7'h3F} and led_year={7'h5B,7'h4F}, all others 0. Expect:
  - seg_o=7'h3F while dig_o[0]=1.
  - seg_o=7'h06 while dig_o[1]=1.
  - seg_o=7'h4F on dig_o[10]; 7'h5B on dig_o[11].
  - frame period = 48 cycles.
- Tearing: change led_min from 0 to 14'h3FFF during slot 5. Expect digits 2 and 3 to show 0 for the rest of the frame and 7'h7F from the next frame.
- Blink: blink_en=1, blink_sel=6'b000100.
  - Expect dig_o bits 4 and 5 to be 0 during frames 2-3 and 6-7.
  - Expect them to be normal in frames 0-1 and 4-5.
  - Expect other digits unaffected.
- Mid-frame reset: assert reset for 1 cycle at slot 7, p=2. Expect dig_o=0 on the next cycle, then the sequence restarting from digit 0 exactly as in the reset check.
- Polarity: rerun the mapping check with SEG_ACTIVE_LOW=1. Expect dig_o=12'hFFE on digit 0 and seg_o=7'h40 for pattern 7'h3F.

Source files
------------

// File: rtl/led_scan_driver.sv
// Multiplexed 12-digit seven-segment scanner fed by the clock/calendar LED buses.
// One digit is lit per slot, with a short blank at the start of each slot and optional field blinking.
module led_scan_driver #(
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 8,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] led_sec,
  input  logic [13:0] led_min,
  input  logic [13:0] led_hour,
  input  logic [13:0] led_day,
  input  logic [13:0] led_month,
  input  logic [13:0] led_year,
  input  logic        blink_en,
  input  logic [5:0]  blink_sel,
  output logic [6:0]  seg_o,
  output logic [11:0] dig_o,
  output logic        frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  function automatic logic [6:0] pol_seg(input logic [6:0] v);
    return (SEG_ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  function automatic logic [11:0] pol_dig(input logic [11:0] v);
    return (SEG_ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  logic [PW-1:0] p_p0;
  logic [3:0]    idx_p0;
  logic [FW-1:0] frame_cnt_p0;
  logic          blink_phase_p0;
  logic [83:0]   snap_p0;

  logic          slot_end;
  logic          frame_end;
  logic          cap;
  logic [11:0]   blink_mask;
  logic          blinked;
  logic [11:0]   dig_nxt;
  logic [6:0]    seg_nxt;

  assign slot_end  = (p_p0 == P_LAST);
  assign frame_end = slot_end && (idx_p0 == 4'd11);
  assign cap       = (p_p0 == '0) && (idx_p0 == 4'd0);

  // Stage p0: scan position, blink timing and frame snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      p_p0           <= '0;
      idx_p0         <= '0;
      frame_cnt_p0   <= '0;
      blink_phase_p0 <= 1'b0;
      snap_p0        <= '0;
    end else begin
      p_p0 <= slot_end ? '0 : p_p0 + 1'b1;
      if (slot_end)
        idx_p0 <= (idx_p0 == 4'd11) ? 4'd0 : idx_p0 + 4'd1;
      if (frame_end) begin
        if (frame_cnt_p0 == F_LAST) begin
          frame_cnt_p0   <= '0;
          blink_phase_p0 <= ~blink_phase_p0;
        end else begin
          frame_cnt_p0 <= frame_cnt_p0 + 1'b1;
        end
      end
      if (cap)
        snap_p0 <= {led_year, led_month, led_day, led_hour, led_min, led_sec};
    end
  end

  always_comb begin
    blink_mask = '0;
    for (int f = 0; f < 6; f++)
      blink_mask[2*f +: 2] = {2{blink_sel[f]}};
    blinked = blink_en && blink_phase_p0 && blink_mask[idx_p0];
    dig_nxt = '0;
    if ((int'(p_p0) >= BLANK_CYC) && !blinked)
      dig_nxt = 12'd1 << idx_p0;
    // The snapshot is still being loaded in the capture cycle, so digit 0 reads the bus directly.
    seg_nxt = cap ? led_sec[6:0] : snap_p0[int'(idx_p0)*7 +: 7];
  end

  // Stage p1: registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_o       <= pol_seg('0);
      dig_o       <= pol_dig('0);
      frame_start <= 1'b0;
    end else begin
      seg_o       <= pol_seg(seg_nxt);
      dig_o       <= pol_dig(dig_nxt);
      frame_start <= cap;
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver with SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.
// An active-low twin instance shares all inputs for the polarity scenario.
module tb_led_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] led_sec = '0, led_min = '0, led_hour = '0;
  logic [13:0] led_day = '0, led_month = '0, led_year = '0;
  logic        blink_en = 1'b0;
  logic [5:0]  blink_sel = '0;
  logic [6:0]  seg_o, seg_al;
  logic [11:0] dig_o, dig_al;
  logic        fs, fs_al;

  int errors = 0;
  int checks = 0;
  logic [13:0] model [6];

  always #5 clk = ~clk;

  led_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset),
    .led_sec(led_sec), .led_min(led_min), .led_hour(led_hour),
    .led_day(led_day), .led_month(led_month), .led_year(led_year),
    .blink_en(blink_en), .blink_sel(blink_sel),
    .seg_o(seg_o), .dig_o(dig_o), .frame_start(fs)
  );

  led_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1)) dut_al (
    .clk(clk), .reset(reset),
    .led_sec(led_sec), .led_min(led_min), .led_hour(led_hour),
    .led_day(led_day), .led_month(led_month), .led_year(led_year),
    .blink_en(blink_en), .blink_sel(blink_sel),
    .seg_o(seg_al), .dig_o(dig_al), .frame_start(fs_al)
  );

  task automatic capture_model();
    model[0] = led_sec;
    model[1] = led_min;
    model[2] = led_hour;
    model[3] = led_day;
    model[4] = led_month;
    model[5] = led_year;
  endtask

  function automatic logic [6:0] pat_of(input int k);
    logic [13:0] f;
    f = model[k/2];
    return (k % 2 == 1) ? f[13:7] : f[6:0];
  endfunction

  // Holds reset for n cycles and returns at the falling edge inside cycle R.
  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] ed;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dig_o !== 12'h000 || seg_o !== 7'h00 || fs !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: dig=%h seg=%h fs=%b, want 000 00 0", dig_o, seg_o, fs);
      end
      checks++;
      if (dig_al !== 12'hFFF || seg_al !== 7'h7F) begin
        errors++;
        $display("FAIL reset_hold_al: dig=%h seg=%h, want fff 7f", dig_al, seg_al);
      end
    end
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      ed = (c >= 2 && c <= 4) ? 12'h001 : (c >= 6) ? 12'h002 : 12'h000;
      checks++;
      if (dig_o !== ed) begin
        errors++;
        $display("FAIL reset_seq_dig R+%0d: got %h want %h", c, dig_o, ed);
      end
      checks++;
      if (fs !== (c == 1)) begin
        errors++;
        $display("FAIL reset_seq_fs R+%0d: got %b want %b", c, fs, (c == 1));
      end
    end
  endtask

  task automatic test_mapping();
    logic [11:0] ed;
    logic [6:0]  es;
    int k, pos;
    led_sec = {7'h06, 7'h3F};
    led_min = '0; led_hour = '0; led_day = '0; led_month = '0;
    led_year = {7'h5B, 7'h4F};
    apply_reset(2);
    capture_model();
    for (int c = 1; c <= 49; c++) begin
      @(negedge clk);
      k = ((c - 1) % 48) / 4;
      pos = (c - 1) % 4;
      ed = (pos >= 1) ? (12'd1 << k) : 12'd0;
      es = pat_of(k);
      checks++;
      if (dig_o !== ed || seg_o !== es) begin
        errors++;
        $display("FAIL map_c%0d: dig=%h seg=%h want dig=%h seg=%h", c, dig_o, seg_o, ed, es);
      end
      checks++;
      if (fs !== (c == 1 || c == 49)) begin
        errors++;
        $display("FAIL map_frame_start c%0d: got %b want %b", c, fs, (c == 1 || c == 49));
      end
      case (c)
        3:  begin checks++; if (seg_o !== 7'h3F) begin errors++; $display("FAIL map_dig0: got %h want 3f", seg_o); end end
        7:  begin checks++; if (seg_o !== 7'h06) begin errors++; $display("FAIL map_dig1: got %h want 06", seg_o); end end
        43: begin checks++; if (seg_o !== 7'h4F) begin errors++; $display("FAIL map_dig10: got %h want 4f", seg_o); end end
        47: begin checks++; if (seg_o !== 7'h5B) begin errors++; $display("FAIL map_dig11: got %h want 5b", seg_o); end end
        default: ;
      endcase
    end
  endtask

  task automatic test_tearing();
    logic [11:0] ed;
    logic [6:0]  es;
    int k, pos;
    led_min = '0;
    led_day = '0;
    apply_reset(2);
    for (int c = 1; c <= 96; c++) begin
      @(negedge clk);
      if ((c - 1) % 48 == 0) capture_model();
      k = ((c - 1) % 48) / 4;
      pos = (c - 1) % 4;
      ed = (pos >= 1) ? (12'd1 << k) : 12'd0;
      es = pat_of(k);
      checks++;
      if (dig_o !== ed || seg_o !== es) begin
        errors++;
        $display("FAIL tear_c%0d: dig=%h seg=%h want dig=%h seg=%h", c, dig_o, seg_o, ed, es);
      end
      case (c)
        26: begin checks++; if (seg_o !== 7'h00) begin errors++; $display("FAIL tear_old_dig6: got %h want 00", seg_o); end end
        58: begin checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL tear_new_dig2: got %h want 7f", seg_o); end end
        62: begin checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL tear_new_dig3: got %h want 7f", seg_o); end end
        74: begin checks++; if (seg_o !== 7'h55) begin errors++; $display("FAIL tear_new_dig6: got %h want 55", seg_o); end end
        default: ;
      endcase
      if (c == 22) begin
        led_min = 14'h3FFF;
        led_day = 14'h2A55;
      end
    end
  endtask

  task automatic test_blink();
    logic [11:0] ed;
    logic [6:0]  es;
    logic        blk;
    int f, k, pos;
    led_hour = {7'h12, 7'h34};
    blink_en = 1'b1;
    blink_sel = 6'b000100;
    apply_reset(2);
    for (int c = 1; c <= 384; c++) begin
      @(negedge clk);
      if ((c - 1) % 48 == 0) capture_model();
      f = (c - 1) / 48;
      k = ((c - 1) % 48) / 4;
      pos = (c - 1) % 4;
      blk = (k == 4 || k == 5) && ((f / 2) % 2 == 1);
      ed = (pos >= 1 && !blk) ? (12'd1 << k) : 12'd0;
      es = pat_of(k);
      checks++;
      if (dig_o !== ed || seg_o !== es) begin
        errors++;
        $display("FAIL blink_f%0d_c%0d: dig=%h seg=%h want dig=%h seg=%h", f, c, dig_o, seg_o, ed, es);
      end
    end
    blink_en = 1'b0;
    blink_sel = '0;
  endtask

  task automatic test_midframe_reset();
    logic [11:0] ed;
    int k, pos;
    apply_reset(2);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      k = (c - 1) / 4;
      pos = (c - 1) % 4;
      ed = (pos >= 1) ? (12'd1 << k) : 12'd0;
      checks++;
      if (dig_o !== ed) begin
        errors++;
        $display("FAIL mid_pre_c%0d: got %h want %h", c, dig_o, ed);
      end
    end
    checks++;
    if (dig_o !== 12'h080) begin
      errors++;
      $display("FAIL mid_slot7: got %h want 080", dig_o);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dig_o !== 12'h000 || seg_o !== 7'h00 || fs !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort: dig=%h seg=%h fs=%b want 000 00 0", dig_o, seg_o, fs);
    end
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      ed = (c >= 2 && c <= 4) ? 12'h001 : (c >= 6) ? 12'h002 : 12'h000;
      checks++;
      if (dig_o !== ed || fs !== (c == 1)) begin
        errors++;
        $display("FAIL mid_restart R+%0d: dig=%h fs=%b want dig=%h fs=%b", c, dig_o, fs, ed, (c == 1));
      end
    end
  endtask

  task automatic test_polarity();
    logic [11:0] ed;
    logic [6:0]  es;
    int k, pos;
    led_sec = {7'h06, 7'h3F};
    led_min = '0; led_hour = '0; led_day = '0; led_month = '0;
    led_year = {7'h5B, 7'h4F};
    apply_reset(2);
    capture_model();
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      k = (c - 1) / 4;
      pos = (c - 1) % 4;
      ed = (pos >= 1) ? (12'd1 << k) : 12'd0;
      es = pat_of(k);
      checks++;
      if (dig_al !== ~ed || seg_al !== ~es || fs_al !== (c == 1)) begin
        errors++;
        $display("FAIL pol_c%0d: dig=%h seg=%h fs=%b want dig=%h seg=%h fs=%b",
                 c, dig_al, seg_al, fs_al, ~ed, ~es, (c == 1));
      end
      if (c == 2) begin
        checks++;
        if (dig_al !== 12'hFFE || seg_al !== 7'h40) begin
          errors++;
          $display("FAIL pol_dig0: dig=%h seg=%h want ffe 40", dig_al, seg_al);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mapping();
    test_tearing();
    test_blink();
    test_midframe_reset();
    test_polarity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
